serial_frame_shifter: RTL and testbench
=======================================

// Module: serial_frame_shifter
// PURPOSE
//  Parametrised serial shift engine that transfers a frame of 1..MAX_WIDTH bits.
//  Full-duplex: parallelIn is shifted out on serialOut while serialIn is shifted in.
//  Generates its own divided serial clock and runs a start/busy/done handshake.
//  Sits under SPI/flash and bit-bang peripherals; software only issues frame requests.
// PARAMETERS
//  MAX_WIDTH  32  largest frame length in bits (>=1)
//  LEN_WIDTH  5   width of frameLength; must be >= max(1, clog2(MAX_WIDTH))
//  DIV_WIDTH  8   width of clockDivide
// PORTS
//  clk           in   1          system clock
//  rst           in   1          synchronous, active-high reset
//  start         in   1          request a frame; sampled only in IDLE
//  frameLength   in   LEN_WIDTH  frame bits minus 1 (0 -> 1 bit); values >= MAX_WIDTH clamp to MAX_WIDTH-1
//  msbFirst      in   1          1: bit N-1 first; 0: bit 0 first
//  clockDivide   in   DIV_WIDTH  half-period of serialClock in clk cycles, minus 1
//  parallelIn    in   MAX_WIDTH  transmit word, right-aligned in [N-1:0]
//  parallelOut   out  MAX_WIDTH  received word, right-aligned, upper bits zero
//  busy          out  1          frame in progress
//  done          out  1          one-cycle pulse at end of frame
//  serialIn      in   1          serial receive data
//  serialOut     out  1          serial transmit data
//  serialClock   out  1          shift clock, idles low
// BEHAVIOUR
//  Reset: state IDLE; parallelOut=0, busy=0, done=0, serialOut=0, serialClock=0.
//   Counters and shift data are cleared. A reset mid-frame aborts the frame with no done pulse.
//  States: IDLE -> LOW -> HIGH -> (LOW | DONE) -> IDLE.
//  IDLE: on start, latch parallelIn, frameLength (N=len+1), msbFirst and clockDivide.
//   Clear bitCount and divCounter. serialOut=first tx bit. Enter LOW next cycle.
//  LOW: serialClock=0, busy=1; lasts clockDivide+1 cycles.
//   On the last cycle: sample serialIn into rx data and enter HIGH.
//  HIGH: serialClock=1, busy=1; lasts clockDivide+1 cycles.
//   On the last cycle: if bitCount==N-1, enter DONE.
//   Otherwise bitCount++, drive the next tx bit on serialOut, and enter LOW.
//  Bit period = 2*(clockDivide+1) clk. Start-to-done = 1 + N*2*(clockDivide+1) cycles.
//  DONE: exactly one cycle. done=1, busy=0, serialClock=0, parallelOut=rx word.
//   The next cycle is IDLE. start is ignored in DONE.
//  serialOut holds its last driven bit through DONE and IDLE until the next start.
//  Tx order: msbFirst sends parallelIn[N-1]..[0]; otherwise [0]..[N-1].
//  Rx order: msbFirst places the first bit in [N-1] and the last in [0].
//   Otherwise the first bit goes in [0] and the last in [N-1].
//   Bits [MAX_WIDTH-1:N] of parallelOut are zero.
//  parallelOut changes only in DONE (and on reset); it is stable otherwise.
//  start while busy or in DONE: ignored, no queueing.
//  Inputs other than serialIn are don't-care after latching.
//  Counters never wrap: divCounter is compared against the latched divide; bitCount is LEN_WIDTH+1 wide.
// STRUCTURE
//  Shared package: state encodings (IDLE/LOW/HIGH/DONE) and the clamp helper for frameLength.
//  Sub-module shift_tick_divider: loadable down-counter that emits a halfPeriodEnd pulse
//   every clockDivide+1 cycles while enabled, restarting on load.
//  Top level holds the FSM, the tx/rx shift registers and the bit counter.
// TESTING
//  MAX_WIDTH=32, len=7, msbFirst=1, div=0, parallelIn=0xA5, serialIn looped to serialOut
//   -> serialOut 1,0,1,0,0,1,0,1; done at cycle 17; parallelOut=0x000000A5.
//  len=7, msbFirst=0, div=3, parallelIn=0x01, serialIn=const 1
//   -> first bit 1 then seven 0s; serialClock period 8 clk; done after 65 cycles; parallelOut=0xFF.
//  len=0 (1 bit), parallelIn=1, serialIn=0 -> one clock pulse; done at cycle 3; parallelOut=0.
//  len=31, msbFirst=1, div=1, parallelIn=0x80000001 loopback
//   -> parallelOut=0x80000001; busy high for 128 cycles.
//  start pulsed mid-frame and in DONE -> ignored; a single done pulse; frame unchanged.
//  rst asserted during HIGH of bit 3 -> next cycle all outputs at reset values; no done; fresh start succeeds.

Source files
------------

// File: rtl/serial_frame_shifter_pkg.sv
// Shared types and helpers for the serial frame shifter.
package serial_frame_shifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_e;

  // Frame length field holds bits-minus-one; anything past the widest frame saturates.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_width);
    return (len >= max_width) ? max_width - 1 : len;
  endfunction

endpackage

// File: rtl/serial_frame_shifter_tick_divider.sv
// Loadable down-counter producing a one-cycle pulse at the end of each serial clock half-period.
module shift_tick_divider
  import serial_frame_shifter_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 en_i,
  output logic                 half_period_end_o
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      div_q <= div_i;
      cnt_q <= div_i;
    end else if (en_i) begin
      cnt_q <= (cnt_q == '0) ? div_q : cnt_q - DIV_WIDTH'(1);
    end
  end

  assign half_period_end_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/serial_frame_shifter.sv
// Full-duplex serial frame engine: shifts parallelIn out on serialOut while capturing serialIn.
module serial_frame_shifter
  import serial_frame_shifter_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 5,
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] frameLength,
  input  logic                 msbFirst,
  input  logic [DIV_WIDTH-1:0] clockDivide,
  input  logic [MAX_WIDTH-1:0] parallelIn,
  output logic [MAX_WIDTH-1:0] parallelOut,
  output logic                 busy,
  output logic                 done,
  input  logic                 serialIn,
  output logic                 serialOut,
  output logic                 serialClock
);

  state_e               state_q, state_d;
  logic [MAX_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, pout_q, pout_d, tx_sh;
  logic [LEN_WIDTH-1:0] len_q, len_d, len_in, align;
  logic [LEN_WIDTH:0]   bit_cnt_q, bit_cnt_d;
  logic                 msb_q, msb_d, sout_q, sout_d;
  logic                 div_load, half_end, last_bit, active;

  assign len_in   = LEN_WIDTH'(clamp_len(32'(frameLength), MAX_WIDTH));
  assign align    = LEN_WIDTH'(MAX_WIDTH - 1) - len_q;
  assign last_bit = (bit_cnt_q == {1'b0, len_q});
  assign active   = (state_q == ST_LOW) || (state_q == ST_HIGH);

  shift_tick_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .clk              (clk),
    .rst              (rst),
    .load_i           (div_load),
    .div_i            (clockDivide),
    .en_i             (active),
    .half_period_end_o(half_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      pout_q    <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      msb_q     <= 1'b0;
      sout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      pout_q    <= pout_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      msb_q     <= msb_d;
      sout_q    <= sout_d;
    end
  end

  // MSB-first frames are pre-aligned to the top so both orders shift out of a fixed end;
  // LSB-first receive fills from the top and is right-aligned when the frame completes.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    pout_d    = pout_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    msb_d     = msb_q;
    sout_d    = sout_q;
    div_load  = 1'b0;
    tx_sh     = msb_q ? (tx_q << 1) : (tx_q >> 1);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          div_load  = 1'b1;
          len_d     = len_in;
          msb_d     = msbFirst;
          bit_cnt_d = '0;
          rx_d      = '0;
          tx_d      = msbFirst ? (parallelIn << (LEN_WIDTH'(MAX_WIDTH - 1) - len_in)) : parallelIn;
          sout_d    = msbFirst ? tx_d[MAX_WIDTH-1] : tx_d[0];
          state_d   = ST_LOW;
        end
      end
      ST_LOW: begin
        if (half_end) begin
          if (msb_q) begin
            rx_d    = rx_q << 1;
            rx_d[0] = serialIn;
          end else begin
            rx_d              = rx_q >> 1;
            rx_d[MAX_WIDTH-1] = serialIn;
          end
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (half_end) begin
          if (last_bit) begin
            pout_d  = msb_q ? rx_q : (rx_q >> align);
            state_d = ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + (LEN_WIDTH + 1)'(1);
            tx_d      = tx_sh;
            sout_d    = msb_q ? tx_sh[MAX_WIDTH-1] : tx_sh[0];
            state_d   = ST_LOW;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign parallelOut = pout_q;
  assign busy        = active;
  assign done        = (state_q == ST_DONE);
  assign serialOut   = sout_q;
  assign serialClock = (state_q == ST_HIGH);

endmodule

// File: tb/tb_serial_frame_shifter.sv
// Scoreboard bench for serial_frame_shifter: directed frames, decoupled done-triggered monitor.
module tb_serial_frame_shifter;

  logic        clk = 1'b0;
  logic        rst, start, msb_first, loop_en, sin_const;
  logic [5:0]  frame_len;
  logic [7:0]  clk_div;
  logic [31:0] pin, pout;
  logic        busy, done, sout, sclk, sin;

  typedef struct {
    logic [31:0] pout;
    int          lat;
    int          bsy;
    logic [31:0] tx;
    int          nb;
    int          hr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  assign sin = loop_en ? sout : sin_const;

  serial_frame_shifter #(.MAX_WIDTH(32), .LEN_WIDTH(6), .DIV_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frameLength(frame_len),
    .msbFirst   (msb_first),
    .clockDivide(clk_div),
    .parallelIn (pin),
    .parallelOut(pout),
    .busy       (busy),
    .done       (done),
    .serialIn   (sin),
    .serialOut  (sout),
    .serialClock(sclk)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: tracks each accepted frame and checks it against the scoreboard on done.
  int          cyc = 0, t0 = 0, bcnt = 0, nb = 0, hr_cur = 0, hr_min = 0, hr_max = 0;
  logic [31:0] txb = '0;
  logic        prev_sclk = 1'b0;
  exp_t        e;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (start && !busy && !done) begin
        t0 = cyc; bcnt = 0; nb = 0; txb = '0; hr_cur = 0; hr_min = 0; hr_max = 0;
      end
      if (busy) bcnt++;
      if (sclk) begin
        if (!prev_sclk) begin
          if (nb < 32) txb[nb] = sout;
          nb++;
        end
        hr_cur++;
      end else if (prev_sclk) begin
        if (hr_min == 0 || hr_cur < hr_min) hr_min = hr_cur;
        if (hr_cur > hr_max) hr_max = hr_cur;
        hr_cur = 0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("parallelOut", 64'(pout), 64'(e.pout));
          chk("latency", 64'(cyc - t0), 64'(e.lat));
          chk("busy_cycles", 64'(bcnt), 64'(e.bsy));
          chk("tx_bits", 64'(txb), 64'(e.tx));
          chk("bit_count", 64'(nb), 64'(e.nb));
          chk("half_period", 64'({hr_min[15:0], hr_max[15:0]}), 64'({e.hr[15:0], e.hr[15:0]}));
          chk("done_phase", 64'({busy, sclk}), 64'(0));
        end
      end
    end
    prev_sclk = sclk;
  end

  task automatic set_inputs(input logic [5:0] len, input logic msb, input logic [7:0] div,
                            input logic [31:0] p, input logic loop, input logic sc);
    @(posedge clk); #1;
    frame_len = len; msb_first = msb; clk_div = div; pin = p; loop_en = loop; sin_const = sc;
  endtask

  task automatic push_exp(input logic [31:0] po, input int lat, input int bsy,
                          input logic [31:0] tx, input int nbits, input int hr);
    exp_t x;
    x.pout = po; x.lat = lat; x.bsy = bsy; x.tx = tx; x.nb = nbits; x.hr = hr;
    exp_q.push_back(x);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (done) return;
    end
    n_vec++; n_fail++;
    $display("FAIL %s_timeout: got no done, expected done within 5000 cycles", name);
  endtask

  task automatic run_frame(input string name, input logic [5:0] len, input logic msb,
                           input logic [7:0] div, input logic [31:0] p, input logic loop,
                           input logic sc, input logic [31:0] po, input int lat,
                           input logic [31:0] tx, input int nbits, input int hr);
    push_exp(po, lat, lat - 1, tx, nbits, hr);
    set_inputs(len, msb, div, p, loop, sc);
    pulse_start();
    wait_done(name);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rises;
    logic prev;
    rst = 1'b1; start = 1'b0; frame_len = '0; msb_first = 1'b0; clk_div = '0;
    pin = '0; loop_en = 1'b0; sin_const = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", 64'({pout, busy, done, sclk, sout}), 64'(0));
    rst = 1'b0;

    //        name       len msb div  parallelIn     loop sin  parallelOut    lat  tx bits       N   hr
    run_frame("a5_msb",  7,  1,  0,   32'hA5,        1,   0,   32'h0000_00A5, 17,  32'hA5,       8,  1);
    run_frame("lsb_div", 7,  0,  3,   32'h01,        0,   1,   32'h0000_00FF, 65,  32'h01,       8,  4);
    run_frame("one_bit", 0,  1,  0,   32'h1,         0,   0,   32'h0,         3,   32'h1,        1,  1);
    run_frame("full32",  31, 1,  1,   32'h8000_0001, 1,   0,   32'h8000_0001, 129, 32'h8000_0001, 32, 2);
    run_frame("upper",   3,  1,  0,   32'hFFFF_FFF5, 1,   0,   32'h5,         9,   32'hA,        4,  1);
    run_frame("lsb_loop",11, 0,  0,   32'hABC,       1,   0,   32'hABC,       25,  32'hABC,      12, 1);
    run_frame("clamp",   40, 1,  0,   32'h1234_5678, 1,   0,   32'h1234_5678, 65,  32'h1E6A_2C48, 32, 1);

    // Start pulses while busy and while in DONE must not queue or alter the frame.
    push_exp(32'h3C, 17, 16, 32'h3C, 8, 1);
    set_inputs(7, 1, 0, 32'h3C, 1, 0);
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1; pin = 32'hFF; frame_len = 6'd2;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("done_when_restart", 64'(done), 64'(1));
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(posedge clk);

    // Reset while bit 3 is in its high phase aborts without a done pulse.
    set_inputs(7, 1, 1, 32'hFF, 1, 0);
    pulse_start();
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 200 && rises < 4; i++) begin
      @(posedge clk); #1;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    chk("abort_reached_bit3", 64'(rises), 64'(4));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_outputs", 64'({pout, busy, done, sclk, sout}), 64'(0));
    repeat (40) @(posedge clk);

    run_frame("after_rst", 7, 1, 0, 32'h5A, 1, 0, 32'h5A, 17, 32'h5A, 8, 1);

    repeat (10) @(posedge clk);
    chk("pending_frames", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
